inst_load_ctrl: RTL and testbench
=================================

INST_LOAD_CTRL -- requirements
Module: inst_load_ctrl

Interface
REQ-001 Parameter MEM_AW, default 12, meaning word-address width of the instruction memory (4096 words).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  CPU fetch request.
REQ-005 if_addr  input  30  CPU fetch word address [31:2].
REQ-006 if_stall  output  1  fetch not accepted this cycle.
REQ-007 if_valid  output  1  if_data holds the result of the fetch accepted last cycle.
REQ-008 if_data  output  32  fetch data, combinational pass-through of mem_rdata.
REQ-009 ld_start  input  1  loader requests ownership of the memory.
REQ-010 ld_valid  input  1  loader write word present.
REQ-011 ld_addr  input  30  loader word address [31:2].
REQ-012 ld_data  input  32  loader write data.
REQ-013 ld_ready  output  1  loader word accepted when ld_valid & ld_ready.
REQ-014 ld_end  input  1  loader finished; releases the memory.
REQ-015 busy  output  1  high in every state except RUN.
REQ-016 word_cnt  output  13  words written in current load session.
REQ-017 checksum  output  32  sum mod 2^32 of ld_data written in current session.
REQ-018 ld_err  output  1  sticky: an out-of-range write was dropped.
REQ-019 mem_addr  output  30  address to instruction memory.
REQ-020 mem_we  output  1  memory write enable.
REQ-021 mem_wdata  output  32  memory write data.
REQ-022 mem_rdata  input  32  memory read data, valid one cycle after mem_addr (registered read).

Function
REQ-023 FSM states SHALL be RUN, DRAIN, LOAD, RESUME; reset state RUN.
REQ-024 RUN: mem_addr=if_addr, mem_we=0, if_stall=0, ld_ready=0; fetch accepted when if_req=1.
REQ-025 if_valid SHALL equal, registered, (if_req & ~if_stall) of the previous cycle; if_valid may be 1 in DRAIN for a fetch accepted in the last RUN cycle.
REQ-026 RUN with ld_start=1 -> DRAIN next cycle; the fetch in the same cycle is still accepted.
REQ-027 DRAIN: exactly 1 cycle, if_stall=1, mem_we=0, ld_ready=0; clears word_cnt, checksum and ld_err; -> LOAD.
REQ-028 LOAD: if_stall=1, ld_ready=1, mem_addr=ld_addr, mem_wdata=ld_data, mem_we=ld_valid & in-range.
REQ-029 In-range SHALL mean ld_addr[31:MEM_AW+2]==0; out-of-range word: mem_we=0, ld_err set, word_cnt/checksum unchanged, still handshaken (consumed).
REQ-030 Each in-range accepted word: word_cnt+1 (saturating at 2^13-1), checksum+=ld_data modulo 2^32.
REQ-031 ld_end in LOAD -> RESUME; if ld_valid also high that cycle the word is written first.
REQ-032 ld_start SHALL be ignored in DRAIN, LOAD, RESUME.
REQ-033 RESUME: exactly 1 cycle, if_stall=1, mem_we=0, ld_ready=0; -> RUN.
REQ-034 if_valid SHALL be 0 in LOAD and RESUME (no fetch accepted in DRAIN/LOAD/RESUME).
REQ-035 word_cnt, checksum, ld_err SHALL hold their values from RUN until the next DRAIN.
REQ-036 mem_we SHALL never be 1 outside LOAD.

Reset
REQ-037 rst_n low SHALL immediately force state RUN, if_valid=0, word_cnt=0, checksum=0, ld_err=0, mem_we=0, ld_ready=0, busy=0.
REQ-038 Reset mid-LOAD SHALL abort the session with no further writes; words already written stay in memory.
REQ-039 Outputs SHALL be stable-defined at the first rising edge after rst_n deasserts; no reset-release write.

Verification
REQ-040 Fetch stream: if_req=1, if_addr 0,1,2 in RUN -> if_valid=1 on following cycles with if_data=mem_rdata, if_stall=0.
REQ-041 Load 3 words addr 0..2 data 0x10,0x20,0x30, then ld_end -> 3 mem_we pulses, word_cnt=3, checksum=0x60, RUN 2 cycles after ld_end.
REQ-042 ld_start with fetch in same cycle -> that fetch gets if_valid=1 in DRAIN; if_stall=1 from DRAIN to RESUME inclusive.
REQ-043 Write to addr 0x1000 (word 4096) -> mem_we=0, ld_err=1, word_cnt unchanged; next ld_start clears ld_err.
REQ-044 ld_valid & ld_end same cycle, data 0xFFFFFFFF after checksum 0x1 -> word written, checksum=0x0, state RESUME.
REQ-045 rst_n low during LOAD with ld_valid=1 -> mem_we=0 immediately, state RUN, counters 0.

Source files
------------

// File: rtl/inst_load_ctrl.sv
// Instruction-memory port arbiter: CPU fetches own the memory in RUN, and a
// loader can take it over for a write session that also tracks count, checksum and range errors.
module inst_load_ctrl #(
    parameter int MEM_AW = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic        if_stall,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [29:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        ld_end,
    output logic        busy,
    output logic [12:0] word_cnt,
    output logic [31:0] checksum,
    output logic        ld_err,
    output logic [29:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        LOAD   = 2'd2,
        RESUME = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_ifValid;
    logic [12:0] r_wordCnt;
    logic [31:0] r_checksum;
    logic        r_ldErr;
    logic        w_inRange;
    logic        w_accept;
    logic        w_writeOk;

    // A word is in range when no address bit above the memory size is set.
    assign w_inRange = ((ld_addr >> MEM_AW) == 30'd0);
    assign w_accept  = (r_state == LOAD) && ld_valid;
    assign w_writeOk = w_accept && w_inRange;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if_stall    = 1'b1;
        busy        = 1'b1;
        ld_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = if_addr;
        case (r_state)
            RUN: begin
                if_stall = 1'b0;
                busy     = 1'b0;
                if (ld_start) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                w_nextState = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                mem_addr = ld_addr;
                mem_we   = w_writeOk;
                if (ld_end) begin
                    w_nextState = RESUME;
                end
            end
            RESUME: begin
                w_nextState = RUN;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifValid <= 1'b0;
        end else begin
            r_ifValid <= if_req && !if_stall;
        end
    end

    // Session statistics are cleared on entry to a session and otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wordCnt  <= 13'd0;
            r_checksum <= 32'd0;
            r_ldErr    <= 1'b0;
        end else if (r_state == DRAIN) begin
            r_wordCnt  <= 13'd0;
            r_checksum <= 32'd0;
            r_ldErr    <= 1'b0;
        end else if (w_accept) begin
            if (w_inRange) begin
                if (r_wordCnt != 13'h1FFF) begin
                    r_wordCnt <= r_wordCnt + 13'd1;
                end
                r_checksum <= r_checksum + ld_data;
            end else begin
                r_ldErr <= 1'b1;
            end
        end
    end

    assign if_valid  = r_ifValid;
    assign if_data   = mem_rdata;
    assign mem_wdata = ld_data;
    assign word_cnt  = r_wordCnt;
    assign checksum  = r_checksum;
    assign ld_err    = r_ldErr;

endmodule

// File: tb/tb_inst_load_ctrl.sv
// Bench for inst_load_ctrl: a registered-read memory behind the DUT, a shadow
// memory and session model derived from the load rules, and scenario tasks.
module tb_inst_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [29:0] if_addr;
    logic        if_stall;
    logic        if_valid;
    logic [31:0] if_data;
    logic        ld_start;
    logic        ld_valid;
    logic [29:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_end;
    logic        busy;
    logic [12:0] word_cnt;
    logic [31:0] checksum;
    logic        ld_err;
    logic [29:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        v;
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    logic [31:0] mem    [4096];
    logic [31:0] refMem [4096];
    ent_t        q[$];
    logic [12:0] expCnt;
    logic [31:0] expSum;
    logic        expErr;
    int          nCompared;
    int          nMismatched;

    inst_load_ctrl #(.MEM_AW(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_stall  (if_stall),
        .if_valid  (if_valid),
        .if_data   (if_data),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_end    (ld_end),
        .busy      (busy),
        .word_cnt  (word_cnt),
        .checksum  (checksum),
        .ld_err    (ld_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[11:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[11:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ld_start = 1'b0; ld_valid = 1'b0;
        ld_addr = '0; ld_data = '0; ld_end = 1'b0;
        tick(); tick();
        #1;
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_busy got=%0b exp=0", busy); end
        nCompared++; if (if_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_stall got=%0b exp=0", if_stall); end
        nCompared++; if (if_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_valid got=%0b exp=0", if_valid); end
        nCompared++; if (ld_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_ready got=%0b exp=0", ld_ready); end
        nCompared++; if (mem_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_we got=%0b exp=0", mem_we); end
        nCompared++; if (word_cnt !== 13'd0) begin nMismatched++; $display("[TB] FAIL rst_cnt got=%0d exp=0", word_cnt); end
        nCompared++; if (checksum !== 32'd0) begin nMismatched++; $display("[TB] FAIL rst_sum got=%h exp=0", checksum); end
        nCompared++; if (ld_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_err got=%0b exp=0", ld_err); end
        rst_n = 1'b1;
        tick();
        nCompared++; if (busy !== 1'b0 || mem_we !== 1'b0 || if_valid !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL rel_outputs got busy=%0b we=%0b valid=%0b exp=0,0,0", busy, mem_we, if_valid);
        end
    endtask

    // Fetch stream in RUN: first three addresses 0,1,2, then random requests.
    task automatic test_fetch(input int n);
        logic        prevReq;
        logic [29:0] prevAddr;
        prevReq = 1'b0; prevAddr = '0;
        for (int i = 0; i < n; i++) begin
            if_req  = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            if_addr = (i < 3) ? 30'(i) : 30'($urandom_range(0, 4095));
            #1;
            nCompared++; if (if_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL fetch_stall i=%0d got=%0b exp=0", i, if_stall); end
            nCompared++; if (mem_addr !== if_addr) begin nMismatched++; $display("[TB] FAIL fetch_addr i=%0d got=%h exp=%h", i, mem_addr, if_addr); end
            nCompared++; if (if_valid !== prevReq) begin nMismatched++; $display("[TB] FAIL fetch_valid i=%0d got=%0b exp=%0b", i, if_valid, prevReq); end
            if (prevReq) begin
                nCompared++; if (if_data !== refMem[prevAddr[11:0]]) begin
                    nMismatched++; $display("[TB] FAIL fetch_data i=%0d got=%h exp=%h", i, if_data, refMem[prevAddr[11:0]]);
                end
            end
            prevReq = if_req; prevAddr = if_addr;
            tick();
        end
        if_req = 1'b0;
        tick();
    endtask

    // Plays the queued loader words as one session; the last entry carries ld_end.
    task automatic run_load(input logic [29:0] fetchAddr);
        int n;
        logic expWe;
        n = q.size();
        ld_start = 1'b1; if_req = 1'b1; if_addr = fetchAddr; ld_valid = 1'b0; ld_end = 1'b0;
        #1;
        nCompared++; if (if_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL start_stall got=%0b exp=0", if_stall); end
        tick();
        ld_start = 1'b1; if_req = 1'b1; ld_valid = 1'b1; ld_addr = 30'd9; ld_data = $urandom;
        #1;
        nCompared++; if (if_stall !== 1'b1 || busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL drain_stall got stall=%0b busy=%0b exp=1,1", if_stall, busy); end
        nCompared++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL drain_port got ready=%0b we=%0b exp=0,0", ld_ready, mem_we); end
        nCompared++; if (if_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL drain_valid got=%0b exp=1", if_valid); end
        nCompared++; if (if_data !== refMem[fetchAddr[11:0]]) begin nMismatched++; $display("[TB] FAIL drain_data got=%h exp=%h", if_data, refMem[fetchAddr[11:0]]); end
        tick();
        expCnt = '0; expSum = '0; expErr = 1'b0;
        for (int k = 0; k < n; k++) begin
            ld_valid = q[k].v; ld_addr = q[k].a; ld_data = q[k].d;
            ld_end = (k == n - 1); ld_start = 1'($urandom_range(0, 1)); if_req = 1'($urandom_range(0, 1));
            expWe = q[k].v && (q[k].a < 30'd4096);
            #1;
            nCompared++; if (ld_ready !== 1'b1 || if_stall !== 1'b1 || busy !== 1'b1) begin
                nMismatched++; $display("[TB] FAIL load_flags k=%0d got ready=%0b stall=%0b busy=%0b exp=1,1,1", k, ld_ready, if_stall, busy);
            end
            nCompared++; if (if_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_valid k=%0d got=%0b exp=0", k, if_valid); end
            nCompared++; if (word_cnt !== expCnt || checksum !== expSum || ld_err !== expErr) begin
                nMismatched++; $display("[TB] FAIL load_stats k=%0d got cnt=%0d sum=%h err=%0b exp cnt=%0d sum=%h err=%0b", k, word_cnt, checksum, ld_err, expCnt, expSum, expErr);
            end
            nCompared++; if (mem_we !== expWe) begin nMismatched++; $display("[TB] FAIL load_we k=%0d got=%0b exp=%0b", k, mem_we, expWe); end
            if (expWe) begin
                nCompared++; if (mem_addr !== q[k].a || mem_wdata !== q[k].d) begin
                    nMismatched++; $display("[TB] FAIL load_wr k=%0d got %h/%h exp %h/%h", k, mem_addr, mem_wdata, q[k].a, q[k].d);
                end
            end
            if (q[k].v) begin
                if (q[k].a < 30'd4096) begin
                    refMem[q[k].a[11:0]] = q[k].d;
                    if (expCnt != 13'd8191) expCnt = expCnt + 13'd1;
                    expSum = expSum + q[k].d;
                end else begin
                    expErr = 1'b1;
                end
            end
            tick();
        end
        ld_valid = 1'b1; ld_addr = 30'd11; ld_end = 1'b0; ld_start = 1'b1; if_req = 1'b1;
        #1;
        nCompared++; if (if_stall !== 1'b1 || busy !== 1'b1 || ld_ready !== 1'b0 || mem_we !== 1'b0 || if_valid !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL resume_flags got stall=%0b busy=%0b ready=%0b we=%0b valid=%0b exp=1,1,0,0,0", if_stall, busy, ld_ready, mem_we, if_valid);
        end
        nCompared++; if (word_cnt !== expCnt || checksum !== expSum || ld_err !== expErr) begin
            nMismatched++; $display("[TB] FAIL resume_stats got cnt=%0d sum=%h err=%0b exp cnt=%0d sum=%h err=%0b", word_cnt, checksum, ld_err, expCnt, expSum, expErr);
        end
        tick();
        ld_valid = 1'b0; ld_start = 1'b0; if_req = 1'b0;
        #1;
        nCompared++; if (busy !== 1'b0 || if_stall !== 1'b0 || ld_ready !== 1'b0 || if_valid !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL run_flags got busy=%0b stall=%0b ready=%0b valid=%0b exp=0,0,0,0", busy, if_stall, ld_ready, if_valid);
        end
        tick();
        nCompared++; if (word_cnt !== expCnt || checksum !== expSum || ld_err !== expErr) begin
            nMismatched++; $display("[TB] FAIL run_hold got cnt=%0d sum=%h err=%0b exp cnt=%0d sum=%h err=%0b", word_cnt, checksum, ld_err, expCnt, expSum, expErr);
        end
        q.delete();
    endtask

    task automatic test_three_words();
        q.push_back('{1'b1, 30'd0, 32'h10});
        q.push_back('{1'b1, 30'd1, 32'h20});
        q.push_back('{1'b1, 30'd2, 32'h30});
        run_load(30'd5);
        nCompared++; if (word_cnt !== 13'd3 || checksum !== 32'h60) begin
            nMismatched++; $display("[TB] FAIL three_words got cnt=%0d sum=%h exp cnt=3 sum=60", word_cnt, checksum);
        end
    endtask

    task automatic test_out_of_range();
        q.push_back('{1'b1, 30'd40, 32'hABCD});
        q.push_back('{1'b1, 30'h1000, 32'h1234});
        q.push_back('{1'b0, 30'd41, 32'h0});
        run_load(30'd40);
        nCompared++; if (ld_err !== 1'b1 || word_cnt !== 13'd1) begin
            nMismatched++; $display("[TB] FAIL oor_stats got err=%0b cnt=%0d exp err=1 cnt=1", ld_err, word_cnt);
        end
    endtask

    task automatic test_wrap_end();
        q.push_back('{1'b1, 30'd50, 32'h1});
        q.push_back('{1'b1, 30'd51, 32'hFFFF_FFFF});
        run_load(30'd51);
        nCompared++; if (checksum !== 32'h0 || ld_err !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL wrap_sum got sum=%h err=%0b exp sum=0 err=0", checksum, ld_err);
        end
    endtask

    task automatic test_random_loads(input int sessions);
        for (int s = 0; s < sessions; s++) begin
            int n;
            n = $urandom_range(1, 40);
            for (int k = 0; k < n; k++) begin
                ent_t e;
                e.v = ($urandom_range(0, 3) != 0);
                e.a = ($urandom_range(0, 7) == 0) ? (30'($urandom) | 30'h1000) : 30'($urandom_range(0, 4095));
                e.d = $urandom;
                q.push_back(e);
            end
            run_load(30'($urandom_range(0, 4095)));
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 8195; k++) begin
            q.push_back('{1'b1, 30'($urandom_range(0, 4095)), $urandom});
        end
        run_load(30'd0);
        nCompared++; if (word_cnt !== 13'h1FFF) begin nMismatched++; $display("[TB] FAIL sat_cnt got=%0d exp=8191", word_cnt); end
    endtask

    task automatic test_reset_mid_load();
        ld_start = 1'b1; if_req = 1'b0; ld_valid = 1'b0; ld_end = 1'b0;
        tick();
        ld_start = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1; ld_addr = 30'(700 + k); ld_data = $urandom;
            #1;
            nCompared++; if (mem_we !== 1'b1) begin nMismatched++; $display("[TB] FAIL rml_we k=%0d got=%0b exp=1", k, mem_we); end
            refMem[ld_addr[11:0]] = ld_data;
            tick();
        end
        ld_addr = 30'd702; ld_data = $urandom;
        rst_n = 1'b0;
        #1;
        nCompared++; if (mem_we !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b0 || if_stall !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL rml_flags got we=%0b busy=%0b ready=%0b stall=%0b exp=0,0,0,0", mem_we, busy, ld_ready, if_stall);
        end
        nCompared++; if (word_cnt !== 13'd0 || checksum !== 32'd0 || ld_err !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL rml_stats got cnt=%0d sum=%h err=%0b exp 0,0,0", word_cnt, checksum, ld_err);
        end
        tick();
        rst_n = 1'b1; ld_valid = 1'b0;
        tick();
    endtask

    // Fetch every word back and compare against the shadow memory.
    task automatic test_readback();
        if_req = 1'b1; if_addr = 30'd0;
        tick();
        for (int a = 1; a <= 4096; a++) begin
            if_addr = 30'(a % 4096);
            #1;
            nCompared++; if (if_valid !== 1'b1 || if_data !== refMem[a - 1]) begin
                nMismatched++; $display("[TB] FAIL readback addr=%0d got valid=%0b data=%h exp valid=1 data=%h", a - 1, if_valid, if_data, refMem[a - 1]);
            end
            tick();
        end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        nCompared = 0; nMismatched = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        test_reset();
        test_fetch(40);
        test_three_words();
        test_out_of_range();
        test_wrap_end();
        test_random_loads(12);
        test_saturate();
        test_fetch(20);
        test_reset_mid_load();
        test_readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
